// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer.
// States, opcodes, datapath select codes and the control bundle.
package mc_pkg;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_EXECUTE   = 4'd7,
      S_ALU_WB    = 4'd8,
      S_BRANCH    = 4'd9,
      S_JUMP      = 4'd10
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwrite_cond;
      logic       iord;
      logic       irwrite;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsource;
      logic       illegal;
      logic       retire;
   } ctrl_t;

   function automatic logic is_mem_op(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: steps shared ALU and unified memory port.
// Moore outputs per state plus Mealy strobes on the memory ready cycle.
module multicycle_control
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       pcwrite_cond,
   output logic       iord,
   output logic       irwrite,
   output logic       memread,
   output logic       memwrite,
   output logic       memtoreg,
   output logic       regdst,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsource,
   output logic       illegal,
   output logic       retire,
   output logic [3:0] state
);

   state_t state_q;
   state_t state_d;
   ctrl_t  c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      c       = '0;
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            c.memread  = 1'b1;
            c.iord     = 1'b0;
            c.alusrca  = 1'b0;
            c.alusrcb  = SRCB_FOUR;
            c.aluop    = ALUOP_ADD;
            c.pcsource = PCSRC_ALU;
            // IR and PC load only once memory delivers the word
            if (mem_ready) begin
               c.irwrite = 1'b1;
               c.pcwrite = 1'b1;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            c.alusrca = 1'b0;
            c.alusrcb = SRCB_IMM_SH;
            c.aluop   = ALUOP_ADD;
            if (is_mem_op(opcode)) begin
               state_d = S_MEM_ADDR;
            end else begin
               case (opcode)
                  OP_RTYPE: state_d = S_EXECUTE;
                  OP_BEQ:   state_d = S_BRANCH;
                  OP_J:     state_d = S_JUMP;
                  default: begin
                     c.illegal = 1'b1;
                     state_d   = S_FETCH;
                  end
               endcase
            end
         end
         S_MEM_ADDR: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_IMM;
            c.aluop   = ALUOP_ADD;
            state_d   = (opcode == OP_SW) ? S_MEM_WRITE
                                          : S_MEM_READ;
         end
         S_MEM_READ: begin
            c.memread = 1'b1;
            c.iord    = 1'b1;
            if (mem_ready) begin
               state_d = S_MEM_WB;
            end
         end
         S_MEM_WB: begin
            c.regdst   = 1'b0;
            c.memtoreg = 1'b1;
            c.regwrite = 1'b1;
            c.retire   = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WRITE: begin
            c.memwrite = 1'b1;
            c.iord     = 1'b1;
            if (mem_ready) begin
               c.retire = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_EXECUTE: begin
            c.alusrca = 1'b1;
            c.alusrcb = SRCB_RT;
            c.aluop   = ALUOP_FUNCT;
            state_d   = S_ALU_WB;
         end
         S_ALU_WB: begin
            c.regdst   = 1'b1;
            c.regwrite = 1'b1;
            c.memtoreg = 1'b0;
            c.retire   = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            c.alusrca      = 1'b1;
            c.alusrcb      = SRCB_RT;
            c.aluop        = ALUOP_SUB;
            c.pcwrite_cond = 1'b1;
            c.pcsource     = PCSRC_ALUOUT;
            c.retire       = 1'b1;
            state_d        = S_FETCH;
         end
         S_JUMP: begin
            c.pcwrite  = 1'b1;
            c.pcsource = PCSRC_JUMP;
            c.retire   = 1'b1;
            state_d    = S_FETCH;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign pcwrite      = c.pcwrite;
   assign pcwrite_cond = c.pcwrite_cond;
   assign iord         = c.iord;
   assign irwrite      = c.irwrite;
   assign memread      = c.memread;
   assign memwrite     = c.memwrite;
   assign memtoreg     = c.memtoreg;
   assign regdst       = c.regdst;
   assign regwrite     = c.regwrite;
   assign alusrca      = c.alusrca;
   assign alusrcb      = c.alusrcb;
   assign aluop        = c.aluop;
   assign pcsource     = c.pcsource;
   assign illegal      = c.illegal;
   assign retire       = c.retire;
   assign state        = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// cycle by cycle against hand-written state and control vectors.
module tb_multicycle_control;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pcwrite;
   logic       pcwrite_cond;
   logic       iord;
   logic       irwrite;
   logic       memread;
   logic       memwrite;
   logic       memtoreg;
   logic       regdst;
   logic       regwrite;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] aluop;
   logic [1:0] pcsource;
   logic       illegal;
   logic       retire;
   logic [3:0] state;

   int checks   = 0;
   int failures = 0;

   localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2,
      MADDR = 4'd3, MREAD = 4'd4, MWB = 4'd5, MWRITE = 4'd6,
      EXEC = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9, JUMP = 4'd10;

   // field order: pw pwc iord irw mr mw m2r rd rw asa asb aop psrc ill ret
   localparam logic [17:0] C_ZERO   = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
   localparam logic [17:0] C_FETCHR = 18'b1_0_0_1_1_0_0_0_0_0_01_00_00_0_0;
   localparam logic [17:0] C_FETCHW = 18'b0_0_0_0_1_0_0_0_0_0_01_00_00_0_0;
   localparam logic [17:0] C_DECODE = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
   localparam logic [17:0] C_DECILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
   localparam logic [17:0] C_MADDR  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
   localparam logic [17:0] C_MREAD  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
   localparam logic [17:0] C_MWB    = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_1;
   localparam logic [17:0] C_MWRW   = 18'b0_0_1_0_0_1_0_0_0_0_00_00_00_0_0;
   localparam logic [17:0] C_MWRR   = 18'b0_0_1_0_0_1_0_0_0_0_00_00_00_0_1;
   localparam logic [17:0] C_EXEC   = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
   localparam logic [17:0] C_ALUWB  = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_1;
   localparam logic [17:0] C_BRANCH = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_1;
   localparam logic [17:0] C_JUMP   = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_1;

   wire [17:0] ctrl = {pcwrite, pcwrite_cond, iord, irwrite, memread,
                       memwrite, memtoreg, regdst, regwrite, alusrca,
                       alusrcb, aluop, pcsource, illegal, retire};

   multicycle_control dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .mem_ready    (mem_ready),
      .pcwrite      (pcwrite),
      .pcwrite_cond (pcwrite_cond),
      .iord         (iord),
      .irwrite      (irwrite),
      .memread      (memread),
      .memwrite     (memwrite),
      .memtoreg     (memtoreg),
      .regdst       (regdst),
      .regwrite     (regwrite),
      .alusrca      (alusrca),
      .alusrcb      (alusrcb),
      .aluop        (aluop),
      .pcsource     (pcsource),
      .illegal      (illegal),
      .retire       (retire),
      .state        (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; inputs are then changed well clear of the edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic expect_cycle(input string tag, input logic [3:0] s_exp,
                               input logic [17:0] c_exp);
      #1;
      checks++;
      assert (state === s_exp) else begin
         failures++;
         $error("FAIL %s state: observed=%0d expected=%0d", tag, state, s_exp);
      end
      checks++;
      assert (ctrl === c_exp) else begin
         failures++;
         $error("FAIL %s ctrl: observed=%b expected=%b", tag, ctrl, c_exp);
      end
      checks++;
      assert (!(memread && memwrite)) else begin
         failures++;
         $error("FAIL %s rd_wr_excl: observed=%b%b expected=not 11",
                tag, memread, memwrite);
      end
   endtask

   initial begin
      reset     = 1'b1;
      opcode    = 6'b000000;
      mem_ready = 1'b1;
      #1 reset  = 1'b0;
      expect_cycle("rst0", IDLE, C_ZERO);
      tick(); expect_cycle("rst1", IDLE, C_ZERO);
      tick(); expect_cycle("rst2", IDLE, C_ZERO);
      tick(); expect_cycle("rst3", IDLE, C_ZERO);
      reset = 1'b1;
      expect_cycle("rel_idle", IDLE, C_ZERO);
      tick(); expect_cycle("first_fetch", FETCH, C_FETCHR);

      // R-type: 4 cycles
      opcode = 6'b000000;
      tick(); expect_cycle("r_decode", DECODE, C_DECODE);
      tick(); expect_cycle("r_exec", EXEC, C_EXEC);
      tick(); expect_cycle("r_wb", ALUWB, C_ALUWB);
      tick(); expect_cycle("r_fetch", FETCH, C_FETCHR);

      // lw with two wait cycles in MEM_READ: 7 cycles
      opcode = 6'b100011;
      tick(); expect_cycle("lw_decode", DECODE, C_DECODE);
      tick(); expect_cycle("lw_addr", MADDR, C_MADDR);
      tick(); mem_ready = 1'b0;
      expect_cycle("lw_rd0", MREAD, C_MREAD);
      tick(); expect_cycle("lw_rd1", MREAD, C_MREAD);
      tick(); mem_ready = 1'b1;
      expect_cycle("lw_rd2", MREAD, C_MREAD);
      tick(); expect_cycle("lw_wb", MWB, C_MWB);
      tick(); expect_cycle("lw_fetch", FETCH, C_FETCHR);

      // FETCH wait: strobes held, no IR/PC load
      mem_ready = 1'b0;
      expect_cycle("fetch_wait0", FETCH, C_FETCHW);
      tick(); expect_cycle("fetch_wait1", FETCH, C_FETCHW);
      mem_ready = 1'b1;
      expect_cycle("fetch_ready", FETCH, C_FETCHR);

      // sw: 4 cycles
      opcode = 6'b101011;
      tick(); expect_cycle("sw_decode", DECODE, C_DECODE);
      tick(); expect_cycle("sw_addr", MADDR, C_MADDR);
      tick(); expect_cycle("sw_write", MWRITE, C_MWRR);
      tick(); expect_cycle("sw_fetch", FETCH, C_FETCHR);

      // beq: 3 cycles
      opcode = 6'b000100;
      tick(); expect_cycle("beq_decode", DECODE, C_DECODE);
      tick(); expect_cycle("beq_branch", BRANCH, C_BRANCH);
      tick(); expect_cycle("beq_fetch", FETCH, C_FETCHR);

      // illegal: 2 cycles
      opcode = 6'b111111;
      tick(); expect_cycle("ill_decode", DECODE, C_DECILL);
      tick(); expect_cycle("ill_fetch", FETCH, C_FETCHR);

      // j: 3 cycles, mem_ready ignored outside memory states
      opcode = 6'b000010;
      tick(); mem_ready = 1'b0;
      expect_cycle("j_decode", DECODE, C_DECODE);
      tick(); expect_cycle("j_jump", JUMP, C_JUMP);
      mem_ready = 1'b1;
      tick(); expect_cycle("j_fetch", FETCH, C_FETCHR);

      // reset while MEM_WRITE is stalled
      opcode = 6'b101011;
      tick(); expect_cycle("swr_decode", DECODE, C_DECODE);
      tick(); expect_cycle("swr_addr", MADDR, C_MADDR);
      tick(); mem_ready = 1'b0;
      expect_cycle("swr_wait", MWRITE, C_MWRW);
      reset = 1'b0;
      expect_cycle("swr_reset", IDLE, C_ZERO);
      mem_ready = 1'b1;
      tick(); expect_cycle("swr_hold0", IDLE, C_ZERO);
      tick(); expect_cycle("swr_hold1", IDLE, C_ZERO);
      reset = 1'b1;
      expect_cycle("swr_rel", IDLE, C_ZERO);
      tick(); expect_cycle("swr_refetch", FETCH, C_FETCHR);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
